// File: rtl/sram_1rwnr_wm_sync.sv
`default_nettype none
// ==========================================================================
// sram_1rwnr_wm_sync : 1RW + N read-only port SRAM, byte-lane write mask,
// 1/2-cycle read latency, write/read collision flags. Rev 1.0
// ==========================================================================
module sram_1rwnr_wm_sync #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int WMASK_GRAN   = 8,
  parameter int NUM_RPORTS   = 1,
  parameter int READ_LATENCY = 1,
  parameter int WR_FWD       = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [DATA_WIDTH/WMASK_GRAN-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             dvalid0,
  input  logic [NUM_RPORTS-1:0]            csb_r,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] addr_r,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] dout_r,
  output logic [NUM_RPORTS-1:0]            dvalid_r,
  output logic [NUM_RPORTS-1:0]            collision
);

  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int NP         = NUM_RPORTS + 1;

  if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_err_gran
    $error("sram_1rwnr_wm_sync: DATA_WIDTH must be a multiple of WMASK_GRAN");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_lat
    $error("sram_1rwnr_wm_sync: READ_LATENCY must be 1 or 2");
  end
  if (NUM_RPORTS < 1 || NUM_RPORTS > 4) begin : g_err_nports
    $error("sram_1rwnr_wm_sync: NUM_RPORTS must be in 1..4");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  do_write;
  logic                  do_read0;
  logic [DATA_WIDTH-1:0] write_bits;

  assign do_write = !csb0 && !web0;
  assign do_read0 = !csb0 &&  web0;

  for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane
    assign write_bits[i*WMASK_GRAN +: WMASK_GRAN] = {WMASK_GRAN{wmask0[i]}};
  end

  // Array is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[addr0] <= (mem[addr0] & ~write_bits) | (din0 & write_bits);
    end
  end

  // Index 0 is the RW port, index k+1 is read-only port k.
  logic [NP-1:0]         rd_en;
  logic [DATA_WIDTH-1:0] rd_data  [NP];
  logic [DATA_WIDTH-1:0] out_data [NP];
  logic [NP-1:0]         out_valid;

  assign rd_en[0]   = do_read0;
  assign rd_data[0] = mem[addr0];

  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rport
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] raw;
    logic                  hit;
    logic                  coll_s1;

    assign raddr = addr_r[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign raw   = mem[raddr];
    assign hit   = do_write && (raddr == addr0);

    assign rd_en[k+1]   = !csb_r[k];
    assign rd_data[k+1] = (WR_FWD != 0 && hit) ? ((raw & ~write_bits) | (din0 & write_bits))
                                               : raw;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) coll_s1 <= 1'b0;
      else        coll_s1 <= !csb_r[k] && hit;
    end

    if (READ_LATENCY == 2) begin : g_coll_lat2
      logic coll_s2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coll_s2 <= 1'b0;
        else        coll_s2 <= coll_s1;
      end
      assign collision[k] = coll_s2;
    end else begin : g_coll_lat1
      assign collision[k] = coll_s1;
    end

    assign dout_r[k*DATA_WIDTH +: DATA_WIDTH] = out_data[k+1];
    assign dvalid_r[k]                        = out_valid[k+1];
  end

  // Data registers only load on a completing read, so outputs hold between reads.
  for (genvar p = 0; p < NP; p++) begin : g_pipe
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= rd_en[p];
        if (rd_en[p]) s1_data <= rd_data[p];
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end
      assign out_data[p]  = s2_data;
      assign out_valid[p] = s2_valid;
    end else begin : g_lat1
      assign out_data[p]  = s1_data;
      assign out_valid[p] = s1_valid;
    end
  end

  assign dout0   = out_data[0];
  assign dvalid0 = out_valid[0];

endmodule
`default_nettype wire

// File: tb/tb_sram_1rwnr_wm_sync.sv
`default_nettype none
// tb_sram_1rwnr_wm_sync : scoreboard bench driving two configurations in parallel
// (A: LAT=1 WR_FWD=1, B: LAT=2 WR_FWD=0), both with two read-only ports.
module tb_sram_1rwnr_wm_sync;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          csb0, web0;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [NR-1:0] csb_r;
  logic [NR*AW-1:0] addr_r;

  logic [DW-1:0]    dout0_a, dout0_b;
  logic             dvalid0_a, dvalid0_b;
  logic [NR*DW-1:0] dout_r_a, dout_r_b;
  logic [NR-1:0]    dvalid_r_a, dvalid_r_b, collision_a, collision_b;

  sram_1rwnr_wm_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_GRAN(8), .NUM_RPORTS(NR),
                       .READ_LATENCY(1), .WR_FWD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_a), .dvalid0(dvalid0_a), .csb_r(csb_r), .addr_r(addr_r),
    .dout_r(dout_r_a), .dvalid_r(dvalid_r_a), .collision(collision_a));

  sram_1rwnr_wm_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_GRAN(8), .NUM_RPORTS(NR),
                       .READ_LATENCY(2), .WR_FWD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_b), .dvalid0(dvalid0_b), .csb_r(csb_r), .addr_r(addr_r),
    .dout_r(dout_r_b), .dvalid_r(dvalid_r_b), .collision(collision_b));

  // Stream ids: 0..2 = A port0/r0/r1, 3..5 = B port0/r0/r1.
  typedef struct {
    int          sid;
    logic [31:0] data;
    logic        coll;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Issue edge is cyc+1; dvalid rises at the edge issue+lat-1 and is seen on the next negedge.
  task automatic push_exp(input int sid, input logic [31:0] d, input logic c, input int lat);
    exp_t e;
    e.sid  = sid;
    e.data = d;
    e.coll = c;
    e.cyc  = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic exp_both(input int p, input logic [31:0] da, input logic ca,
                          input logic [31:0] db, input logic cb);
    push_exp(p, da, ca, 1);
    push_exp(3 + p, db, cb, 2);
  endtask

  task automatic mon_one(input int s, input logic v, input logic [31:0] d, input logic c);
    int idx;
    idx = -1;
    if (!v) begin
      if (c) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream%0d collision without dvalid: got 1 at edge %0d, required 0", s, cyc);
      end
      return;
    end
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].sid == s) begin
        idx = i;
        break;
      end
    end
    n_cmp++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL stream%0d unexpected dvalid: got data=%h at edge %0d, required no valid", s, d, cyc);
    end else begin
      if (sb[idx].data !== d || sb[idx].coll !== c || sb[idx].cyc != cyc) begin
        n_bad++;
        $display("FAIL stream%0d read: got data=%h coll=%b edge=%0d, required data=%h coll=%b edge=%0d",
                 s, d, c, cyc, sb[idx].data, sb[idx].coll, sb[idx].cyc);
      end
      sb.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_one(0, dvalid0_a,     dout0_a,         1'b0);
      mon_one(1, dvalid_r_a[0], dout_r_a[31:0],  collision_a[0]);
      mon_one(2, dvalid_r_a[1], dout_r_a[63:32], collision_a[1]);
      mon_one(3, dvalid0_b,     dout0_b,         1'b0);
      mon_one(4, dvalid_r_b[0], dout_r_b[31:0],  collision_b[0]);
      mon_one(5, dvalid_r_b[1], dout_r_b[63:32], collision_b[1]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb_r = '1; addr_r = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic rd0(input logic [7:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
  endtask

  task automatic rdr(input int k, input logic [7:0] a);
    csb_r[k] = 1'b0;
    addr_r[k*AW +: AW] = a;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " dout0_a"},     {32'h0, dout0_a},                      64'h0);
    chk({tag, " dvalid0_a"},   {63'h0, dvalid0_a},                    64'h0);
    chk({tag, " dout_r_a"},    dout_r_a,                              64'h0);
    chk({tag, " flags_a"},     {60'h0, dvalid_r_a, collision_a},      64'h0);
    chk({tag, " dout0_b"},     {32'h0, dout0_b},                      64'h0);
    chk({tag, " dvalid0_b"},   {63'h0, dvalid0_b},                    64'h0);
    chk({tag, " dout_r_b"},    dout_r_b,                              64'h0);
    chk({tag, " flags_b"},     {60'h0, dvalid_r_b, collision_b},      64'h0);
  endtask

  logic [31:0] vec [8];

  initial begin
    vec = '{32'h00C0FFEE, 32'h11111111, 32'h2468ACE0, 32'h33333333,
            32'h4444AAAA, 32'h5A5A5A5A, 32'h600DF00D, 32'h77770007};
    idle();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    // Full write then read on port 0
    idle(); wr(8'h05, 32'hDEADBEEF, 4'hF); step();
    idle(); rd0(8'h05); exp_both(0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0); step();
    // Partial lane write
    idle(); wr(8'h05, 32'h11223344, 4'b0101); step();
    idle(); rd0(8'h05); exp_both(0, 32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0); step();
    // Empty mask is a no-op write
    idle(); wr(8'h05, 32'hFFFFFFFF, 4'b0000); step();
    idle(); rd0(8'h05); exp_both(0, 32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0); step();

    // Collision: A forwards written lanes, B returns old word
    idle(); wr(8'h10, 32'h12345678, 4'hF); step();
    idle(); wr(8'h10, 32'hAABBCCDD, 4'b0011); rdr(0, 8'h10); rdr(1, 8'h05);
    exp_both(1, 32'h1234CCDD, 1'b1, 32'h12345678, 1'b1);
    exp_both(2, 32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0);
    step();
    // Both read ports on the same address, no write: no collision
    idle(); rdr(0, 8'h10); rdr(1, 8'h10);
    exp_both(1, 32'h1234CCDD, 1'b0, 32'h1234CCDD, 1'b0);
    exp_both(2, 32'h1234CCDD, 1'b0, 32'h1234CCDD, 1'b0);
    step();

    // Write one cycle after a read must not disturb captured data
    idle(); wr(8'h20, 32'h55555555, 4'hF); step();
    idle(); rdr(0, 8'h20); exp_both(1, 32'h55555555, 1'b0, 32'h55555555, 1'b0); step();
    idle(); wr(8'h20, 32'h66666666, 4'hF); step();
    idle(); rd0(8'h20); exp_both(0, 32'h66666666, 1'b0, 32'h66666666, 1'b0); step();

    // Streaming reads on all ports every cycle
    for (int i = 0; i < 8; i++) begin
      idle(); wr(8'(i), vec[i], 4'hF); step();
    end
    for (int i = 0; i < 8; i++) begin
      idle(); rd0(8'(i)); rdr(0, 8'(i)); rdr(1, 8'(7 - i));
      exp_both(0, vec[i],     1'b0, vec[i],     1'b0);
      exp_both(1, vec[i],     1'b0, vec[i],     1'b0);
      exp_both(2, vec[7 - i], 1'b0, vec[7 - i], 1'b0);
      step();
    end

    // Address extremes back to back
    idle(); wr(8'hFF, 32'hFFFFFFFF, 4'hF); step();
    idle(); wr(8'h00, 32'h00000000, 4'hF); step();
    idle(); rd0(8'hFF); rdr(0, 8'h00);
    exp_both(0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0);
    exp_both(1, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    step();
    idle(); rd0(8'h00); rdr(0, 8'hFF);
    exp_both(0, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    exp_both(1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0);
    step();
    idle(); repeat (4) step();
    chk("scoreboard drained before reset", 64'(sb.size()), 64'h0);

    // Reset with a read in flight: results dropped, array keeps its contents
    idle(); wr(8'h30, 32'hCAFEF00D, 4'hF); step();
    idle(); rd0(8'h30); rdr(1, 8'h30); step();
    idle(); rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid-op reset");
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    idle(); rd0(8'h30); rdr(1, 8'h30);
    exp_both(0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0);
    exp_both(2, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0);
    step();
    idle(); repeat (5) step();
    chk("scoreboard empty at end", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
